sound_mixer_ng: RTL

- Parametrised next-generation audio mixer for the sound unit. Replaces the combinational 4-channel adder/multiplier mixer.
- Takes N channel levels and snapshots them at a programmable sample rate.
- Accumulates the snapshot time-multiplexed (one channel per cycle) into left/right sums, applies per-side master volume, and pushes stereo samples into an output FIFO.
- The FIFO has a valid/ready handshake toward the audio DAC/I2S block.

---
 rtl/sound_mixer_ng.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sound_mixer_ng.sv
// Stereo sound mixer: snapshots NUM_CH channel levels once per sample period,
// accumulates them one channel per cycle into left/right sums, scales each side
// by its master volume and queues the stereo sample in a small output FIFO.
module sound_mixer_ng #(
    parameter int NUM_CH     = 4,
    parameter int LEVEL_W    = 4,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_DIV = 128
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [NUM_CH*LEVEL_W-1:0]        ch_level,
    input  logic [NUM_CH-1:0]                pan_l,
    input  logic [NUM_CH-1:0]                pan_r,
    input  logic [2:0]                       vol_l,
    input  logic [2:0]                       vol_r,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_left,
    output logic [OUT_W-1:0]                 out_right,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overrun,
    input  logic                             clr_overrun
);
    localparam int ACC_W = LEVEL_W + $clog2(NUM_CH);
    localparam int P_W   = ACC_W + 3;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SHIFT = OUT_W - 1 - P_W;

    typedef enum logic [1:0] {IDLE, ACC, SCALE, PUSH} state_t;

    state_t                    state;
    logic [DIV_W-1:0]          div_cnt;
    logic                      tick;
    logic [IDX_W-1:0]          ch_idx;
    logic [NUM_CH*LEVEL_W-1:0] lvl_snap;
    logic [NUM_CH-1:0]         pl_snap;
    logic [NUM_CH-1:0]         pr_snap;
    logic [2:0]                vl_snap;
    logic [2:0]                vr_snap;
    logic                      snap_en;
    logic [ACC_W-1:0]          acc_l;
    logic [ACC_W-1:0]          acc_r;
    logic [P_W-1:0]            prod_l;
    logic [P_W-1:0]            prod_r;
    logic [LEVEL_W-1:0]        cur_lvl;
    logic                      cur_pl;
    logic                      cur_pr;
    logic                      abort;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      push_ok;
    logic                      drop;
    logic [OUT_W-1:0]          samp_l;
    logic [OUT_W-1:0]          samp_r;
    logic [2*OUT_W-1:0]        mem [FIFO_DEPTH];
    logic [2*OUT_W-1:0]        head;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Free-running sample-rate divider, independent of enable.
    always_ff @(posedge clk) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    // Select the snapshotted level and pan bits of the channel being accumulated.
    always_comb begin
        cur_lvl = '0;
        cur_pl  = 1'b0;
        cur_pr  = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_idx == IDX_W'(k)) begin
                cur_lvl = lvl_snap[k*LEVEL_W +: LEVEL_W];
                cur_pl  = pl_snap[k];
                cur_pr  = pr_snap[k];
            end
        end
    end

    // Only a sample started while enabled is aborted by enable dropping; a muted
    // sample (zeroed snapshot) always completes so the stream stays continuous.
    assign abort = snap_en & ~enable;
    assign push  = (state == PUSH) && !abort;

    // Snapshot / accumulate / scale / push sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ch_idx   <= '0;
            lvl_snap <= '0;
            pl_snap  <= '0;
            pr_snap  <= '0;
            vl_snap  <= '0;
            vr_snap  <= '0;
            snap_en  <= 1'b0;
            acc_l    <= '0;
            acc_r    <= '0;
            prod_l   <= '0;
            prod_r   <= '0;
        end else if (state != IDLE && abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        lvl_snap <= enable ? ch_level : '0;
                        pl_snap  <= enable ? pan_l : '0;
                        pr_snap  <= enable ? pan_r : '0;
                        vl_snap  <= vol_l;
                        vr_snap  <= vol_r;
                        snap_en  <= enable;
                        acc_l    <= '0;
                        acc_r    <= '0;
                        ch_idx   <= '0;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc_l <= acc_l + (cur_pl ? ACC_W'(cur_lvl) : ACC_W'(0));
                    acc_r <= acc_r + (cur_pr ? ACC_W'(cur_lvl) : ACC_W'(0));
                    if (ch_idx == IDX_W'(NUM_CH - 1)) state <= SCALE;
                    else                              ch_idx <= ch_idx + IDX_W'(1);
                end
                SCALE: begin
                    prod_l <= P_W'(acc_l) * P_W'({1'b0, vl_snap} + 4'd1);
                    prod_r <= P_W'(acc_r) * P_W'({1'b0, vr_snap} + 4'd1);
                    state  <= PUSH;
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign samp_l = OUT_W'(prod_l) << SHIFT;
    assign samp_r = OUT_W'(prod_r) << SHIFT;

    assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop     = out_valid & out_ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // FIFO storage; when full with a same-cycle pop, wr_ptr equals rd_ptr and the
    // head is read out before being overwritten at the clock edge.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {samp_l, samp_r};
    end

    // FIFO pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop)             overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    assign out_valid = (fifo_count != '0);
    assign head      = mem[rd_ptr];
    assign out_left  = out_valid ? head[2*OUT_W-1:OUT_W] : '0;
    assign out_right = out_valid ? head[OUT_W-1:0] : '0;

endmodule
